// File: rtl/apb_reg_subordinate_pkg.sv
// Shared types and helpers for the APB register completer.
// Holds the FSM state encoding, prot bit positions and address decode helpers.
package apb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam int unsigned PRIV   = 0;
    localparam int unsigned NONSEC = 1;
    localparam int unsigned INSTR  = 2;

    function automatic int unsigned byte_lanes(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Byte offset from the block base to a register index.
    function automatic logic [63:0] offset_to_index(input logic [63:0] offset,
                                                    input int unsigned data_width);
        return offset >> $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_reg_subordinate_if.sv
// APB signal bundle for one selector lane, with manager and completer views.
interface apb_reg_subordinate_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                   select;
    logic                   enable;
    logic [AddrWidth-1:0]   addr;
    logic [3:0]             prot;
    logic                   write;
    logic [DataWidth-1:0]   wData;
    logic [DataWidth/8-1:0] strb;
    logic                   ready;
    logic [DataWidth-1:0]   rData;
    logic                   subError;

    modport master (
        output select, enable, addr, prot, write, wData, strb,
        input  ready, rData, subError
    );

    modport slave (
        input  select, enable, addr, prot, write, wData, strb,
        output ready, rData, subError
    );
endinterface

// File: rtl/apb_sub_reg.sv
// One data-width register with byte-strobed update, read-only status select
// and a write pulse that follows each committed write by one cycle.
module apb_sub_reg
    import apb_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter bit          ReadOnly  = 1'b0
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   we,
    input  logic [DataWidth-1:0]   wdata,
    input  logic [DataWidth/8-1:0] strb,
    input  logic [DataWidth-1:0]   hw_in,
    output logic [DataWidth-1:0]   value,
    output logic [DataWidth-1:0]   rdata,
    output logic                   pulse
);
    localparam int unsigned Lanes = byte_lanes(DataWidth);

    logic [DataWidth-1:0] value_d;

    // Byte-lane merge: unstrobed lanes keep their stored value.
    always_comb begin
        value_d = value;
        if (we) begin
            for (int b = 0; b < Lanes; b++) begin
                if (strb[b]) begin
                    value_d[b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            value <= '0;
            pulse <= 1'b0;
        end else begin
            value <= value_d;
            pulse <= we;
        end
    end

    assign rdata = ReadOnly ? hw_in : value;

endmodule

// File: rtl/apb_reg_subordinate.sv
// APB completer exposing RegNum registers with programmable wait states,
// byte-strobed writes, read-only status slots and error signalling.
module apb_reg_subordinate
    import apb_pkg::*;
#(
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          RegNum     = 8,
    parameter logic [AddrWidth-1:0] BaseAddr   = '0,
    parameter int unsigned          WaitStates = 1,
    parameter logic [RegNum-1:0]    RoMask     = '0,
    parameter bit                   PrivOnly   = 1'b0
) (
    input  logic                          clk,
    input  logic                          nReset,
    apb_reg_subordinate_if.slave          bus,
    output logic [RegNum*DataWidth-1:0]   regOut,
    input  logic [RegNum*DataWidth-1:0]   hwIn,
    output logic [RegNum-1:0]             wrPulse
);
    localparam int unsigned Lanes = byte_lanes(DataWidth);
    localparam int unsigned CntW  = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;
    localparam int unsigned IdxW  = (RegNum > 1) ? $clog2(RegNum) : 1;
    localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(Lanes - 1);

    localparam logic [0:0] IDLE   = 1'(ST_IDLE);
    localparam logic [0:0] ACCESS = 1'(ST_ACCESS);

    logic [0:0]           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 write_q, write_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [Lanes-1:0]     strb_q, strb_d;
    logic                 priv_q, priv_d;

    logic [AddrWidth-1:0] offset;
    logic [63:0]          idx_full;
    logic [IdxW-1:0]      idx;
    logic                 in_range;
    logic                 misaligned;
    logic                 ro_hit;
    logic                 err_c;
    logic                 ready_c;
    logic                 commit_c;
    logic                 unused_prot;
    logic [DataWidth-1:0] rd_lane [RegNum];

    assign unused_prot = ^{bus.prot[INSTR], bus.prot[NONSEC], bus.prot[3]};

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            priv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            priv_q  <= priv_d;
        end
    end

    // Transfer sequencing; the request is captured once in setup and held.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        priv_d  = priv_q;
        case (state_q)
            IDLE: begin
                if (bus.select && !bus.enable) begin
                    state_d = ACCESS;
                    cnt_d   = CntW'(WaitStates);
                    addr_d  = bus.addr;
                    write_d = bus.write;
                    wdata_d = bus.wData;
                    strb_d  = bus.strb;
                    priv_d  = bus.prot[PRIV];
                end
            end
            ACCESS: begin
                if (!bus.select) begin
                    state_d = IDLE;
                end else if (bus.enable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode of the latched address.
    assign offset     = addr_q - BaseAddr;
    assign idx_full   = offset_to_index(64'(offset), DataWidth);
    assign idx        = IdxW'(idx_full);
    assign in_range   = (addr_q >= BaseAddr) && (idx_full < 64'(RegNum));
    assign misaligned = (offset & AlignMask) != '0;
    assign ro_hit     = in_range && RoMask[idx];
    assign err_c      = misaligned || !in_range || (write_q && ro_hit) ||
                        (PrivOnly && !priv_q);

    assign ready_c  = (state_q == ACCESS) && bus.select && bus.enable && (cnt_q == '0);
    assign commit_c = ready_c && write_q && !err_c;

    assign bus.ready    = ready_c;
    assign bus.subError = ready_c && err_c;
    assign bus.rData    = (ready_c && !err_c && !write_q) ? rd_lane[idx] : '0;

    for (genvar i = 0; i < RegNum; i++) begin : g_reg
        apb_sub_reg #(
            .DataWidth (DataWidth),
            .ReadOnly  (RoMask[i])
        ) u_reg (
            .clk    (clk),
            .nReset (nReset),
            .we     (commit_c && (idx == IdxW'(i))),
            .wdata  (wdata_q),
            .strb   (strb_q),
            .hw_in  (hwIn[i*DataWidth +: DataWidth]),
            .value  (regOut[i*DataWidth +: DataWidth]),
            .rdata  (rd_lane[i]),
            .pulse  (wrPulse[i])
        );
    end

endmodule

// File: doc/apb_reg_subordinate.md
Name: apb_reg_subordinate

Overview:
APB completer (peripheral side) exposing RegNum data-width registers to an APB manager/bridge on the same bus. It answers one selector lane of the common APB signal set: it decodes the address, inserts programmable wait states, applies byte-strobed writes and returns read data. It signals errors for bad addresses, misalignment, read-only writes and privilege violations. Register contents drive hardware directly; read-only slots reflect hardware status inputs.

Parameters:
AddrWidth, 32, address bit-width
DataWidth, 32, data bit-width (multiple of 8)
RegNum, 8, number of registers
BaseAddr, 0, byte address of register 0
WaitStates, 1, access-phase wait cycles before ready (0 = zero-wait)
RoMask, 0, RegNum-bit mask; bit i set = register i read-only (reads hwIn lane i)
PrivOnly, 0, 1 = accesses with prot[0]=0 return error

Ports:
clk  input  1  clock
nReset  input  1  async active-low reset
select  input  1  this peripheral's selector lane
enable  input  1  access-phase indicator
addr  input  AddrWidth  byte address
prot  input  4  protection info
write  input  1  1 write / 0 read
wData  input  DataWidth  write data
strb  input  DataWidth/8  write byte strobes
ready  output  1  transfer complete
rData  output  DataWidth  read data
subError  output  1  transfer error
regOut  output  RegNum*DataWidth  register contents, lane i = register i
hwIn  input  RegNum*DataWidth  status values for read-only registers
wrPulse  output  RegNum  one-cycle pulse on committed write to register i

Behaviour:
- One clock, clk; reset asynchronous and active-low on nReset. Reset: FSM IDLE, all registers 0, wait counter 0, ready/subError/wrPulse 0, rData 0.
- FSM states: IDLE, ACCESS.
- IDLE -> ACCESS on select=1 & enable=0 (setup phase). Latch addr, write, wData, strb, prot. Load counter with WaitStates.
- select=1 & enable=1 in IDLE (no setup) is ignored and the state stays IDLE.
- In ACCESS with select=1 & enable=1: if counter != 0, decrement and keep ready=0. If counter == 0, ready=1 this cycle (combinational from state/counter), then go to IDLE next edge.
- Total transfer length is 2+WaitStates cycles. A new setup on the cycle after completion is accepted: back-to-back transfers with no idle cycle are supported.
- select dropping while in ACCESS: abort, return to IDLE, no write, no pulse.
- Decode: offset = addr-BaseAddr; index = offset >> log2(DataWidth/8).
- Error conditions (any one sets subError):
  - offset low bits nonzero (misaligned)
  - addr < BaseAddr, or index >= RegNum
  - write to a register with its RoMask bit set
  - PrivOnly=1 & prot[0]=0
- subError and rData are driven only while ready=1, and are 0 otherwise.
- Errored transfer: no register change, no pulse, rData 0.
- Write commit occurs at the completing edge (ready=1). For each byte lane b with strb[b]=1, update byte b; lanes with strb[b]=0 hold. wrPulse[index] is high for the cycle after commit, even if strb is all-zero.
- Read: rData = register value for RW registers, or hwIn lane for RO registers. strb is ignored on reads.
- The latched values are used for the whole transfer; bus changes mid-access do not affect the result.
- Reset asserted mid-transfer: immediate return to reset values; the transfer is lost.

Decomposition:
- Shared package apb_pkg: state enum (IDLE, ACCESS), byte-lane count function, address-offset-to-index helper, prot bit position constants (PRIV=0, NONSEC=1, INSTR=2).
- Sub-module apb_sub_reg: one DataWidth register with byte-strobe merge, RO select (hwIn vs stored), write pulse. Generated RegNum times.

Test Plan:
- Reset then read reg 2 (addr 0x08), WaitStates=1 -> ready on 3rd cycle, rData=0, subError=0.
- Write 0xDEADBEEF to 0x04 with strb=0xF, then write 0x000000AA with strb=0x1 -> regOut lane1=0xDEADBEAA; wrPulse[1] pulses twice; readback matches.
- Addr 0x20 (RegNum=8) read, and misaligned write to 0x06 -> subError=1 with ready, rData=0, no register change.
- RoMask=0x01, hwIn lane0=0x12345678: read 0x00 returns 0x12345678; write 0x00 -> subError=1, wrPulse[0] stays 0.
- WaitStates=0 back-to-back write 0x0C then read 0x0C with no idle cycle -> each completes in 2 cycles, read returns the written value.
- Drop select during a wait cycle, and assert nReset mid-write -> no commit; FSM IDLE; all outputs at reset values.
